fifo_rd_fwft_adapter: RTL and testbench

- Read-side stage directly downstream of the FIFO36K read port; both run on the same read clock.
- Converts the FIFO's standard-mode read (RD_EN, data one cycle later) into a first-word-fall-through valid/ready stream.
- Holds a 3-entry elastic buffer so reads are issued credit-based, with no combinational path from O_READY to FIFO_RD_EN.
- Sustains one word per cycle and flags protocol errors from the FIFO.

---
 rtl/fifo_rd_fwft_adapter_if.sv | 26 ++
 rtl/fifo_rd_fwft_adapter.sv | 120 ++++++++++++
 tb/tb_fifo_rd_fwft_adapter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_fwft_adapter_if.sv
// Handshake bundle between the FIFO36K read port, the FWFT adapter and its downstream consumer.
interface fifo_rd_fwft_adapter_if #(
   parameter int DATA_WIDTH = 36
);
   logic                  FIFO_EMPTY;
   logic                  FIFO_UNDERFLOW;
   logic [DATA_WIDTH-1:0] FIFO_RD_DATA;
   logic                  FIFO_RD_EN;
   logic [DATA_WIDTH-1:0] O_DATA;
   logic                  O_VALID;
   logic                  O_READY;
   logic [1:0]            LEVEL;
   logic                  ERR;

   // Environment side: FIFO flags/data and downstream ready.
   modport master (
      output FIFO_EMPTY, FIFO_UNDERFLOW, FIFO_RD_DATA, O_READY,
      input  FIFO_RD_EN, O_DATA, O_VALID, LEVEL, ERR
   );

   // Adapter side.
   modport slave (
      input  FIFO_EMPTY, FIFO_UNDERFLOW, FIFO_RD_DATA, O_READY,
      output FIFO_RD_EN, O_DATA, O_VALID, LEVEL, ERR
   );
endinterface

// File: rtl/fifo_rd_fwft_adapter.sv
// Standard-mode FIFO read port to first-word-fall-through stream, using a 3-entry
// credit-managed elastic buffer so FIFO_RD_EN never depends on O_READY.
module fifo_rd_fwft_adapter #(
   parameter int DATA_WIDTH = 36
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     FLUSH,
   fifo_rd_fwft_adapter_if.slave    bus
);

   if (!(DATA_WIDTH == 9 || DATA_WIDTH == 18 || DATA_WIDTH == 36)) begin : g_bad_width
      $error("fifo_rd_fwft_adapter: DATA_WIDTH must be 9, 18 or 36");
   end

   logic [DATA_WIDTH-1:0] mem_q [3];
   logic [DATA_WIDTH-1:0] mem_d [3];
   logic [1:0]            wr_ptr_q, wr_ptr_d;
   logic [1:0]            rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;
   logic                  inflight_q, inflight_d;
   logic                  err_q, err_d;

   logic                  rd_en_s;
   logic                  pop_s;
   logic                  push_s;
   logic                  overflow_s;
   logic [DATA_WIDTH-1:0] head_s;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      logic [1:0] r;
      case (p)
         2'd0:    r = 2'd1;
         2'd1:    r = 2'd2;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   // Credit check uses registered state only; RESET gating keeps the FIFO idle while held in reset.
   always_comb begin
      rd_en_s    = RESET & ~FLUSH & ~bus.FIFO_EMPTY &
                   (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
      pop_s      = (count_q != 2'd0) & bus.O_READY;
      overflow_s = inflight_q & (count_q == 2'd3);
      push_s     = inflight_q & ((count_q != 2'd3) | pop_s);
   end

   // Head-of-buffer mux; pointer value 3 is never reached.
   always_comb begin
      case (rd_ptr_q)
         2'd0:    head_s = mem_q[0];
         2'd1:    head_s = mem_q[1];
         2'd2:    head_s = mem_q[2];
         default: head_s = {DATA_WIDTH{1'b0}};
      endcase
   end

   // Next-state for buffer, pointers, credit and sticky error.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      inflight_d = rd_en_s;
      err_d      = err_q | bus.FIFO_UNDERFLOW;
      if (FLUSH) begin
         wr_ptr_d   = 2'd0;
         rd_ptr_d   = 2'd0;
         count_d    = 2'd0;
         inflight_d = 1'b0;
      end else begin
         err_d = err_q | bus.FIFO_UNDERFLOW | overflow_s;
         if (push_s) begin
            mem_d[wr_ptr_q] = bus.FIFO_RD_DATA;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         mem_q[0]   <= {DATA_WIDTH{1'b0}};
         mem_q[1]   <= {DATA_WIDTH{1'b0}};
         mem_q[2]   <= {DATA_WIDTH{1'b0}};
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign bus.FIFO_RD_EN = rd_en_s;
   assign bus.O_VALID    = (count_q != 2'd0);
   assign bus.O_DATA     = head_s;
   assign bus.LEVEL      = count_q;
   assign bus.ERR        = err_q;

endmodule

// File: tb/tb_fifo_rd_fwft_adapter.sv
// Scoreboard bench: a behavioural FIFO36K read port feeds the adapter; words are queued as expected when loaded.
module tb_fifo_rd_fwft_adapter;

   logic CLK;
   logic RESET;
   logic FLUSH;

   fifo_rd_fwft_adapter_if #(.DATA_WIDTH(36)) bus ();

   fifo_rd_fwft_adapter #(.DATA_WIDTH(36)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .FLUSH (FLUSH),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [35:0] fifo_q [$];
   logic [35:0] exp_q  [$];
   int total = 0;
   int bad   = 0;
   int cyc = 0;
   int popped = 0;
   int accepted = 0;
   int rden_cnt = 0;
   int rden_first = -1;
   int rden_last = -1;
   int acc_first = -1;
   int acc_last = -1;
   logic rdy_rand = 1'b0;
   logic rdy_const = 1'b1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: monitor at negedge, FIFO model and ready update just after posedge.
   task automatic step();
      logic rd_seen;
      logic [35:0] e;
      @(negedge CLK);
      rd_seen = bus.FIFO_RD_EN;
      if (rd_seen) begin
         rden_cnt++;
         if (rden_first < 0) rden_first = cyc;
         rden_last = cyc;
      end
      if (RESET && bus.O_VALID && bus.O_READY) begin
         check_eq("sb_avail", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("o_data", 64'(bus.O_DATA), 64'(e));
         end
         accepted++;
         if (acc_first < 0) acc_first = cyc;
         acc_last = cyc;
      end
      @(posedge CLK);
      #1;
      cyc++;
      if (rd_seen && fifo_q.size() != 0) begin
         bus.FIFO_RD_DATA = fifo_q.pop_front();
         popped++;
      end
      bus.FIFO_EMPTY = (fifo_q.size() == 0);
      bus.O_READY    = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_const;
      #1;
   endtask

   task automatic load(input logic [35:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic clear_marks();
      rden_cnt = 0; rden_first = -1; rden_last = -1;
      acc_first = -1; acc_last = -1;
   endtask

   task automatic drain(input string tag, input int bound);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) step();
      check_eq(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int acc0;
      int n;
      RESET = 1'b0;
      FLUSH = 1'b0;
      bus.FIFO_EMPTY     = 1'b1;
      bus.FIFO_UNDERFLOW = 1'b0;
      bus.FIFO_RD_DATA   = 36'd0;
      bus.O_READY        = 1'b1;
      #3;
      check_eq("rst_valid", 64'(bus.O_VALID), 64'd0);
      check_eq("rst_level", 64'(bus.LEVEL), 64'd0);
      check_eq("rst_err",   64'(bus.ERR), 64'd0);
      check_eq("rst_rden",  64'(bus.FIFO_RD_EN), 64'd0);
      check_eq("rst_data",  64'(bus.O_DATA), 64'd0);
      step(); step();
      RESET = 1'b1;
      step(); step();

      // Single word: RD_EN only at cycle 0, valid at cycle 2.
      clear_marks();
      load(36'h1_2345_6789);
      bus.FIFO_EMPTY = 1'b0;
      #1;
      check_eq("sw_rden_c0", 64'(bus.FIFO_RD_EN), 64'd1);
      step();
      check_eq("sw_rden_c1", 64'(bus.FIFO_RD_EN), 64'd0);
      check_eq("sw_valid_c1", 64'(bus.O_VALID), 64'd0);
      step();
      check_eq("sw_valid_c2", 64'(bus.O_VALID), 64'd1);
      check_eq("sw_data_c2", 64'(bus.O_DATA), 64'h1_2345_6789);
      step();
      check_eq("sw_valid_c3", 64'(bus.O_VALID), 64'd0);
      check_eq("sw_level_c3", 64'(bus.LEVEL), 64'd0);
      check_eq("sw_rden_cnt", 64'(rden_cnt), 64'd1);

      // Streaming 100 words with ready held high.
      clear_marks();
      acc0 = accepted;
      for (int i = 0; i < 100; i++) load(36'(i));
      bus.FIFO_EMPTY = 1'b0;
      drain("st_drain", 300);
      step(); step();
      check_eq("st_count", 64'(accepted - acc0), 64'd100);
      check_eq("st_no_bubble", 64'(acc_last - acc_first), 64'd99);
      check_eq("st_rden_cnt", 64'(rden_cnt), 64'd100);
      check_eq("st_rden_cont", 64'(rden_last - rden_first), 64'd99);
      check_eq("st_err", 64'(bus.ERR), 64'd0);

      // Backpressure: only three credits with ready low.
      clear_marks();
      acc0 = accepted;
      rdy_const = 1'b0;
      bus.O_READY = 1'b0;
      for (int i = 0; i < 10; i++) load(36'(500 + i));
      bus.FIFO_EMPTY = 1'b0;
      repeat (8) step();
      check_eq("bp_rden_cnt", 64'(rden_cnt), 64'd3);
      check_eq("bp_level", 64'(bus.LEVEL), 64'd3);
      check_eq("bp_rden_low", 64'(bus.FIFO_RD_EN), 64'd0);
      rdy_const = 1'b1;
      bus.O_READY = 1'b1;
      drain("bp_drain", 100);
      check_eq("bp_count", 64'(accepted - acc0), 64'd10);

      // Random ready over 1000 words.
      acc0 = accepted;
      rdy_rand = 1'b1;
      for (int i = 0; i < 1000; i++) load(36'($urandom));
      bus.FIFO_EMPTY = 1'b0;
      drain("rnd_drain", 8000);
      rdy_rand = 1'b0;
      step(); step();
      check_eq("rnd_count", 64'(accepted - acc0), 64'd1000);
      check_eq("rnd_err", 64'(bus.ERR), 64'd0);

      // Flush with inflight=1 and LEVEL=2.
      acc0 = accepted;
      rdy_const = 1'b0;
      bus.O_READY = 1'b0;
      for (int i = 0; i < 10; i++) load(36'(200 + i));
      bus.FIFO_EMPTY = 1'b0;
      step(); step(); step();
      check_eq("fl_level_pre", 64'(bus.LEVEL), 64'd2);
      FLUSH = 1'b1;
      #1;
      check_eq("fl_rden", 64'(bus.FIFO_RD_EN), 64'd0);
      step();
      FLUSH = 1'b0;
      #1;
      check_eq("fl_valid", 64'(bus.O_VALID), 64'd0);
      check_eq("fl_level", 64'(bus.LEVEL), 64'd0);
      n = popped - accepted;
      check_eq("fl_discard", 64'(n), 64'd3);
      for (int i = 0; i < n; i++) void'(exp_q.pop_front());
      rdy_const = 1'b1;
      drain("fl_drain", 100);
      check_eq("fl_count", 64'(accepted - acc0), 64'd7);

      // Underflow sets a sticky error that survives flush but not reset.
      bus.FIFO_UNDERFLOW = 1'b1;
      step();
      bus.FIFO_UNDERFLOW = 1'b0;
      check_eq("er_set", 64'(bus.ERR), 64'd1);
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      check_eq("er_flush", 64'(bus.ERR), 64'd1);
      rdy_const = 1'b0;
      bus.O_READY = 1'b0;
      for (int i = 0; i < 5; i++) load(36'(900 + i));
      bus.FIFO_EMPTY = 1'b0;
      #1;
      step(); step();
      check_eq("ar_pre_valid", 64'(bus.O_VALID), 64'd1);
      check_eq("ar_pre_rden", 64'(bus.FIFO_RD_EN), 64'd1);
      #2;
      RESET = 1'b0;
      #1;
      check_eq("ar_err", 64'(bus.ERR), 64'd0);
      check_eq("ar_valid", 64'(bus.O_VALID), 64'd0);
      check_eq("ar_level", 64'(bus.LEVEL), 64'd0);
      check_eq("ar_rden", 64'(bus.FIFO_RD_EN), 64'd0);
      fifo_q.delete();
      exp_q.delete();
      bus.FIFO_EMPTY = 1'b1;
      step();
      RESET = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
